// File: rtl/v_wb_sequencer_if.sv
// Result-side write-back bundle: lane-array capture inputs, VRF write channel, status pulses.
// slave = sequencer, master = control unit / VRF side that drives it.
interface v_wb_sequencer_if #(
    parameter int DW = 128,
    parameter int AW = 5
);
    logic          done;
    logic          is_mul;
    logic [2:0]    lmul;
    logic [AW-1:0] vd;
    logic [DW-1:0] result_valu_1;
    logic [DW-1:0] result_valu_2;
    logic [DW-1:0] result_valu_3;
    logic [DW-1:0] result_valu_4;
    logic [DW-1:0] result_vmul_1;
    logic [DW-1:0] result_vmul_2;
    logic [DW-1:0] result_vmul_3;
    logic [DW-1:0] result_vmul_4;
    logic          vrf_we;
    logic [AW-1:0] vrf_waddr;
    logic [DW-1:0] vrf_wdata;
    logic          vrf_wready;
    logic          busy;
    logic          wb_done;
    logic          err_cfg;
    logic          err_ovr;

    modport slave (
        input  done, is_mul, lmul, vd,
        input  result_valu_1, result_valu_2, result_valu_3, result_valu_4,
        input  result_vmul_1, result_vmul_2, result_vmul_3, result_vmul_4,
        input  vrf_wready,
        output vrf_we, vrf_waddr, vrf_wdata,
        output busy, wb_done, err_cfg, err_ovr
    );

    modport master (
        output done, is_mul, lmul, vd,
        output result_valu_1, result_valu_2, result_valu_3, result_valu_4,
        output result_vmul_1, result_vmul_2, result_vmul_3, result_vmul_4,
        output vrf_wready,
        input  vrf_we, vrf_waddr, vrf_wdata,
        input  busy, wb_done, err_cfg, err_ovr
    );
endinterface

// File: rtl/v_wb_sequencer.sv
// Write-back sequencer: captures four ALU/MUL result groups on a done rise, writes 1/2/4 of them to VRF.
// Latency: first write valid the cycle after start; wb_done the cycle after the last accepted write.
// Backpressure: we/addr/data held until vrf_wready; starts while busy are dropped and flagged on err_ovr.
module v_wb_sequencer #(
    parameter int DW   = 128,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input logic             clk,
    input logic             nrst,
    v_wb_sequencer_if.slave io_wb
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_done_q;
    logic [DW-1:0] r_buf [4];
    logic [AW-1:0] r_base;
    logic [1:0]    r_last;
    logic [1:0]    r_cnt;
    logic          r_err_cfg;
    logic          r_err_ovr;

    logic          w_start;
    logic          w_idle;
    logic          w_accept;
    logic          w_reserved;
    logic          w_misalign;
    logic [1:0]    w_last_in;
    logic [AW:0]   w_sum;
    logic [AW-1:0] w_waddr;
    logic          w_we;
    logic          w_wb_done;
    logic [DW-1:0] w_wdata;

    assign w_start  = io_wb.done & ~r_done_q;
    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_we & io_wb.vrf_wready;

    // r_last holds n-1, so it doubles as the alignment mask for vd
    always_comb begin
        w_last_in  = 2'd0;
        w_reserved = 1'b0;
        case (io_wb.lmul)
            3'd0:    w_last_in = 2'd0;
            3'd1:    w_last_in = 2'd1;
            3'd2:    w_last_in = 2'd3;
            default: w_reserved = 1'b1;
        endcase
    end

    assign w_misalign = |(io_wb.vd[1:0] & w_last_in);

    assign w_sum   = {1'b0, r_base} + {{(AW-1){1'b0}}, r_cnt};
    assign w_waddr = (w_sum >= (AW+1)'(NREG)) ? AW'(w_sum - (AW+1)'(NREG)) : AW'(w_sum);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_wdata     = '0;
        w_wb_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_we    = 1'b1;
                w_wdata = r_buf[r_cnt];
                if (io_wb.vrf_wready && (r_cnt == r_last)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_wb_done   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_done_q  <= 1'b0;
            r_base    <= '0;
            r_last    <= 2'd0;
            r_cnt     <= 2'd0;
            r_err_cfg <= 1'b0;
            r_err_ovr <= 1'b0;
            for (int i = 0; i < 4; i++) r_buf[i] <= '0;
        end else begin
            r_done_q  <= io_wb.done;
            r_err_cfg <= w_start & w_idle & (w_reserved | w_misalign);
            r_err_ovr <= w_start & ~w_idle;
            if (w_start && w_idle) begin
                r_base <= io_wb.vd;
                r_last <= w_last_in;
                r_cnt  <= 2'd0;
                if (io_wb.is_mul) begin
                    r_buf[0] <= io_wb.result_vmul_1;
                    r_buf[1] <= io_wb.result_vmul_2;
                    r_buf[2] <= io_wb.result_vmul_3;
                    r_buf[3] <= io_wb.result_vmul_4;
                end else begin
                    r_buf[0] <= io_wb.result_valu_1;
                    r_buf[1] <= io_wb.result_valu_2;
                    r_buf[2] <= io_wb.result_valu_3;
                    r_buf[3] <= io_wb.result_valu_4;
                end
            end else if (w_accept && (r_cnt != r_last)) begin
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

    assign io_wb.vrf_we    = w_we;
    assign io_wb.vrf_waddr = w_we ? w_waddr : '0;
    assign io_wb.vrf_wdata = w_wdata;
    assign io_wb.busy      = ~w_idle;
    assign io_wb.wb_done   = w_wb_done;
    assign io_wb.err_cfg   = r_err_cfg;
    assign io_wb.err_ovr   = r_err_ovr;
endmodule

// File: doc/v_wb_sequencer.md
Name: v_wb_sequencer

Overview:
- Write-back sequencer on the result side of the vector lane array.
- Captures the four 128-bit ALU or MUL result groups when the lanes assert done.
- Writes the 1, 2 or 4 groups selected by LMUL to consecutive vector-register-file entries, one entry per accepted write, using a valid/ready handshake.
- Reports completion, overrun and configuration errors to the vector control unit.

Parameters:
- DW, 128, width of one result group and one VRF write.
- NREG, 32, number of vector registers.
- AW, 5, VRF address width (log2 NREG).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- nrst  in  1  asynchronous active-low reset.
- done  in  1  lane array has finished; a rising edge is sampled as the start event.
- is_mul  in  1  1: write back MUL results; 0: write back ALU results. Sampled with done.
- lmul  in  3  0 → 1 group; 1 → 2 groups; 2 → 4 groups; 3–7 reserved. Sampled with done.
- vd  in  AW  base destination register. Sampled with done.
- result_valu_1..4  in  DW each  ALU result groups 1–4.
- result_vmul_1..4  in  DW each  MUL result groups 1–4.
- vrf_we  out  1  write valid.
- vrf_waddr  out  AW  write address.
- vrf_wdata  out  DW  write data.
- vrf_wready  in  1  VRF accepts the write this cycle.
- busy  out  1  a capture or write sequence is in progress.
- wb_done  out  1  one-cycle pulse after the last write is accepted.
- err_cfg  out  1  one-cycle pulse for reserved lmul or misaligned vd.
- err_ovr  out  1  one-cycle pulse when done rises while busy.

Behaviour:
- Reset (async, nrst=0): state IDLE; vrf_we, busy, wb_done, err_cfg and err_ovr are 0; vrf_waddr=0; vrf_wdata=0; internal count and capture buffer cleared. Reset mid-sequence abandons the sequence; no further writes are issued.
- Start detection: a registered copy done_q is kept; start = done & ~done_q.
- IDLE:
  - On start, latch all four groups of the selected source (MUL if is_mul=1, else ALU) into a 4×DW buffer.
  - Latch base=vd and n = 1/2/4 from lmul. Reserved lmul → n=1 and err_cfg pulses.
  - Set cnt=0 and go to WRITE.
- Misaligned vd (vd mod n ≠ 0): err_cfg pulses on the cycle after start, but the writes still proceed.
- WRITE:
  - vrf_we=1, vrf_waddr=(base+cnt) mod NREG, vrf_wdata=buf[cnt].
  - Address, data and we stay stable until vrf_wready=1.
  - On a cycle with we & wready: if cnt==n-1, go to DONE; else cnt++. Back-to-back writes occur when wready is held high.
- DONE: vrf_we=0; wb_done=1 for exactly one cycle; return to IDLE.
- busy=1 in WRITE and DONE; 0 in IDLE.
- Latency with vrf_wready held high:
  - Start sampled at edge E; first write valid during the cycle after E.
  - Last write accepted at edge E+n; wb_done high during the cycle after E+n.
  - busy drops one cycle later.
- Overrun: start while busy is ignored. The buffer and sequence are unaffected, and err_ovr pulses for one cycle.
- Start edges:
  - done held high does not retrigger.
  - done rising in the same cycle that wb_done is asserted (state DONE) counts as overrun.
  - The next valid start is the cycle after busy drops.
- Address wrap: base=31 with n=2 writes 31, then 0.
- Result inputs may change after capture; writes always use the captured data.

Test Plan:
- lmul=0, is_mul=0, vd=5, result_valu_1=128'hA1, done pulse, wready=1 → single write addr 5 data A1; wb_done high during the cycle after that write is accepted; no errors.
- lmul=2, is_mul=1, vd=8, result_vmul_1..4=B1..B4, wready=1 → writes 8/B1, 9/B2, 10/B3, 11/B4 on consecutive cycles; wb_done pulses once.
- lmul=1, vd=4, wready pattern 0,0,1,0,1 → addr 4 held stable for 3 cycles, then addr 5 held for 2 cycles; exactly 2 writes accepted.
- lmul=1, vd=31 → err_cfg pulse (misaligned); writes go to 31 then 0.
- lmul=5 → err_cfg pulse; exactly one write to vd. Done retoggled mid-sequence → err_ovr pulse; write count unchanged.
- nrst asserted during the second of four writes → vrf_we=0 immediately; busy=0; after release, no residual writes; a new start works normally.
